fetch_ctrl: RTL and testbench

//  Front-end sequencer that owns the PC and schedules I-cache requests for the core.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic        kill;
  } fetch_tag_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the redirect, I-cache and decode handshakes seen by fetch_ctrl.
interface fetch_if;
  logic        redir_i;
  logic [31:0] redir_pc_i;
  logic        ic_req_valid_o;
  logic        ic_req_ready_i;
  logic [31:0] ic_req_addr_o;
  logic        ic_rsp_valid_i;
  logic [31:0] ic_rsp_data_i;
  logic        ic_rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_err_o;

  modport master (
    input  redir_i, redir_pc_i, ic_req_ready_i, ic_rsp_valid_i, ic_rsp_data_i, ic_rsp_err_i,
           inst_ready_i,
    output ic_req_valid_o, ic_req_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o
  );

  modport slave (
    output redir_i, redir_pc_i, ic_req_ready_i, ic_rsp_valid_i, ic_rsp_data_i, ic_rsp_err_i,
           inst_ready_i,
    input  ic_req_valid_o, ic_req_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; reads zero when empty.
module fetch_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  T                wdata_i,
  input  logic            pop_i,
  output T                rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o,
  output logic            full_o
);

  T                mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign count_o = cnt_q;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (!empty_o) rdata_o = mem_q[rptr_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues I-cache requests under a credit limit,
// drops responses made stale by a redirect and buffers the rest for decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned FBUF_DEPTH      = 4
) (
  input logic      clk_i,
  input logic      rst_i,
  fetch_if.master  bus
);

  localparam int unsigned OstW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FbW  = $clog2(FBUF_DEPTH + 1);

  logic [31:0]     pc_q, pc_d;
  logic [OstW-1:0] outstanding_q, outstanding_d;
  logic [OstW-1:0] kill_cnt_q, kill_cnt_d;

  logic            credit_ok, req_valid, issue;
  logic            rsp_pop, rsp_kill, fbuf_push, fbuf_pop, inst_valid;

  fetch_tag_t      tag_wdata, tag_head;
  logic [OstW-1:0] tag_cnt;
  logic            tag_empty, tag_full;

  fetch_entry_t    fbuf_wdata, fbuf_head;
  logic [FbW-1:0]  fbuf_cnt;
  logic            fbuf_empty, fbuf_full;

  // Redirect always kills every live tag and those are the oldest in the queue,
  // so a count of leading killed tags stands in for per-entry kill bits.
  always_comb begin
    credit_ok = (32'(outstanding_q) < MAX_OUTSTANDING) &&
                ((32'(outstanding_q) + 32'(fbuf_cnt)) < FBUF_DEPTH);
    req_valid = !rst_i && !bus.redir_i && credit_ok;
    issue     = req_valid && bus.ic_req_ready_i;

    rsp_pop    = bus.ic_rsp_valid_i && !tag_empty;
    rsp_kill   = tag_head.kill || (kill_cnt_q != '0) || bus.redir_i;
    fbuf_push  = rsp_pop && !rsp_kill;
    inst_valid = !fbuf_empty && !bus.redir_i;
    fbuf_pop   = inst_valid && bus.inst_ready_i;

    tag_wdata  = '{pc: word_align(pc_q), kill: 1'b0};
    fbuf_wdata = '{pc: tag_head.pc, inst: bus.ic_rsp_data_i, err: bus.ic_rsp_err_i};

    pc_d = pc_q;
    if (bus.redir_i)  pc_d = word_align(bus.redir_pc_i);
    else if (issue)   pc_d = word_align(pc_q) + 32'd4;

    outstanding_d = outstanding_q;
    if (issue && !rsp_pop)      outstanding_d = outstanding_q + 1'b1;
    else if (!issue && rsp_pop) outstanding_d = outstanding_q - 1'b1;

    kill_cnt_d = kill_cnt_q;
    if (bus.redir_i)                      kill_cnt_d = outstanding_d;
    else if (rsp_pop && kill_cnt_q != '0) kill_cnt_d = kill_cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= word_align(RESET_PC);
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
    end
  end

  fetch_fifo #(
    .T     (fetch_tag_t),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (1'b0),
    .push_i  (issue),
    .wdata_i (tag_wdata),
    .pop_i   (rsp_pop),
    .rdata_o (tag_head),
    .count_o (tag_cnt),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FBUF_DEPTH)
  ) u_fbuf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (bus.redir_i),
    .push_i  (fbuf_push),
    .wdata_i (fbuf_wdata),
    .pop_i   (fbuf_pop),
    .rdata_o (fbuf_head),
    .count_o (fbuf_cnt),
    .empty_o (fbuf_empty),
    .full_o  (fbuf_full)
  );

  assign bus.ic_req_valid_o = req_valid;
  assign bus.ic_req_addr_o  = word_align(pc_q);
  assign bus.inst_valid_o   = inst_valid;
  assign bus.inst_o         = fbuf_empty ? NOP : fbuf_head.inst;
  assign bus.inst_pc_o      = fbuf_head.pc;
  assign bus.inst_err_o     = fbuf_head.err;

`ifndef SYNTHESIS
  a_rsp_has_tag: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.ic_rsp_valid_i |-> !tag_empty);
  a_ost_match: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding_q == tag_cnt);
  a_tag_no_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
    issue |-> !tag_full || rsp_pop);
  a_fbuf_no_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
    fbuf_push |-> !fbuf_full);
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected requests/instructions are queued by
// the stimulus and checked by negedge monitors against an in-order I-cache model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  fetch_if bus ();

  fetch_ctrl #(
    .RESET_PC        (32'h0000_0000),
    .MAX_OUTSTANDING (2),
    .FBUF_DEPTH      (4)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int unsigned  cyc = 0;
  int unsigned  rsp_lat = 1;
  logic [31:0]  err_addr = 32'hFFFF_FFFF;
  pend_t        pend[$];
  logic [31:0]  exp_req[$];
  fetch_entry_t exp_inst[$];

  function automatic logic [31:0] mkinst(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic [31:0] a);
    exp_req.push_back(a);
  endtask

  task automatic push_inst(input logic [31:0] a);
    exp_inst.push_back('{pc: a, inst: mkinst(a), err: (a == err_addr)});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic start_test(input int unsigned lat);
    rst_i = 1'b1;
    bus.redir_i        = 1'b0;
    bus.redir_pc_i     = 32'h0;
    bus.ic_req_ready_i = 1'b1;
    bus.inst_ready_i   = 1'b1;
    rsp_lat            = lat;
    step(2);
  endtask

  task automatic end_test(input string name, input int drain);
    bus.ic_req_ready_i = 1'b0;
    bus.inst_ready_i   = 1'b1;
    step(drain);
    chk({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
    chk({name, "_inst_left"}, 32'(exp_inst.size()), 32'd0);
    exp_req.delete();
    exp_inst.delete();
  endtask

  // In-order I-cache model, one response per cycle after rsp_lat cycles.
  initial begin
    pend_t p;
    bus.ic_rsp_valid_i = 1'b0;
    bus.ic_rsp_data_i  = 32'h0;
    bus.ic_rsp_err_i   = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) pend.delete();
      else if (bus.ic_req_valid_o && bus.ic_req_ready_i)
        pend.push_back('{addr: bus.ic_req_addr_o, due: cyc + rsp_lat});
      @(posedge clk_i);
      cyc++;
      #1;
      if (!rst_i && pend.size() != 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        bus.ic_rsp_valid_i = 1'b1;
        bus.ic_rsp_data_i  = mkinst(p.addr);
        bus.ic_rsp_err_i   = (p.addr == err_addr);
      end else begin
        bus.ic_rsp_valid_i = 1'b0;
        bus.ic_rsp_data_i  = 32'h0;
        bus.ic_rsp_err_i   = 1'b0;
      end
    end
  end

  // Monitors: compare every handshake against the head of its expected queue.
  always @(negedge clk_i) begin
    fetch_entry_t e;
    if (!rst_i && bus.ic_req_valid_o && bus.ic_req_ready_i) begin
      if (exp_req.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL req_unexpected: got addr %h, required no request", bus.ic_req_addr_o);
      end else begin
        chk("req_addr", bus.ic_req_addr_o, exp_req.pop_front());
      end
    end
    if (!rst_i && bus.inst_valid_o && bus.inst_ready_i) begin
      if (exp_inst.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL inst_unexpected: got pc %h, required no instruction", bus.inst_pc_o);
      end else begin
        e = exp_inst.pop_front();
        chk("inst_pc", bus.inst_pc_o, e.pc);
        chk("inst_word", bus.inst_o, e.inst);
        chk("inst_err", {31'b0, bus.inst_err_o}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    bus.redir_i        = 1'b0;
    bus.redir_pc_i     = 32'h0;
    bus.ic_req_ready_i = 1'b1;
    bus.inst_ready_i   = 1'b1;
    #1 rst_i = 1'b1;
    #2;
    chk("rst_req_valid", {31'b0, bus.ic_req_valid_o}, 32'd0);
    chk("rst_req_addr", bus.ic_req_addr_o, 32'h0);
    chk("rst_inst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
    chk("rst_inst", bus.inst_o, 32'h0);
    chk("rst_inst_pc", bus.inst_pc_o, 32'h0);
    chk("rst_inst_err", {31'b0, bus.inst_err_o}, 32'd0);

    // 1: streaming, one request per cycle, decode one cycle after each response
    start_test(1);
    for (int i = 0; i < 8; i++) begin
      push_req(32'(i * 4));
      push_inst(32'(i * 4));
    end
    rst_i = 1'b0;
    step(1);
    chk("t1_no_comb_path", {31'b0, bus.inst_valid_o}, 32'd0);
    step(1);
    chk("t1_lat_valid", {31'b0, bus.inst_valid_o}, 32'd1);
    chk("t1_lat_pc", bus.inst_pc_o, 32'h0);
    step(6);
    end_test("t1", 5);

    // 2: decode stalled, buffer fills to 4 and requests stop
    start_test(1);
    bus.inst_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_req(32'(i * 4));
      push_inst(32'(i * 4));
    end
    rst_i = 1'b0;
    step(6);
    chk("t2_req_stopped", {31'b0, bus.ic_req_valid_o}, 32'd0);
    chk("t2_full_valid", {31'b0, bus.inst_valid_o}, 32'd1);
    chk("t2_head_pc", bus.inst_pc_o, 32'h0);
    chk("t2_four_issued", 32'(exp_req.size()), 32'd0);
    end_test("t2", 6);

    // 3: redirect with 0x8 and 0xC outstanding
    start_test(3);
    push_req(32'h0);  push_req(32'h4);  push_req(32'h8);  push_req(32'hC);
    push_req(32'h100);
    push_inst(32'h0); push_inst(32'h4); push_inst(32'h100);
    rst_i = 1'b0;
    step(6);
    bus.redir_i    = 1'b1;
    bus.redir_pc_i = 32'h100;
    #1;
    chk("t3_redir_no_req", {31'b0, bus.ic_req_valid_o}, 32'd0);
    step(1);
    bus.redir_i = 1'b0;
    step(1);
    chk("t3_new_addr", bus.ic_req_addr_o, 32'h100);
    chk("t3_new_valid", {31'b0, bus.ic_req_valid_o}, 32'd1);
    step(1);
    end_test("t3", 8);

    // 4: redirect coincides with a response and a valid instruction
    start_test(1);
    push_req(32'h0); push_req(32'h4); push_req(32'h200);
    push_inst(32'h200);
    rst_i = 1'b0;
    step(2);
    chk("t4_pre_valid", {31'b0, bus.inst_valid_o}, 32'd1);
    bus.redir_i    = 1'b1;
    bus.redir_pc_i = 32'h200;
    #1;
    chk("t4_redir_inst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
    chk("t4_redir_req_valid", {31'b0, bus.ic_req_valid_o}, 32'd0);
    step(1);
    bus.redir_i = 1'b0;
    #1;
    chk("t4_buf_empty", {31'b0, bus.inst_valid_o}, 32'd0);
    step(1);
    end_test("t4", 5);

    // 5: I-cache stalls three cycles at 0x20
    start_test(1);
    for (int i = 0; i < 9; i++) begin
      push_req(32'(i * 4));
      push_inst(32'(i * 4));
    end
    rst_i = 1'b0;
    step(8);
    bus.ic_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) step(1);
      else #1;
      chk("t5_stall_addr", bus.ic_req_addr_o, 32'h20);
      chk("t5_stall_valid", {31'b0, bus.ic_req_valid_o}, 32'd1);
    end
    step(1);
    bus.ic_req_ready_i = 1'b1;
    step(1);
    chk("t5_next_addr", bus.ic_req_addr_o, 32'h24);
    end_test("t5", 6);

    // 6: redirect to the top of memory, faulting first fetch, PC wrap
    start_test(1);
    err_addr           = 32'hFFFF_FFFC;
    bus.redir_i        = 1'b1;
    bus.redir_pc_i     = 32'hFFFF_FFFE;
    push_req(32'hFFFF_FFFC); push_req(32'h0);
    push_inst(32'hFFFF_FFFC); push_inst(32'h0);
    rst_i = 1'b0;
    step(1);
    bus.redir_i = 1'b0;
    #1;
    chk("t6_top_addr", bus.ic_req_addr_o, 32'hFFFF_FFFC);
    step(1);
    chk("t6_wrap_addr", bus.ic_req_addr_o, 32'h0);
    step(1);
    end_test("t6", 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
